// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - 3x3 binary sliding-window generator over a raster pixel stream.
// Optional: define WINGEN_OVERRUN_ERR_EN to add the sticky overrun output err.

module window_gen_3x3 #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pix_valid,
   input  logic       pix_in,
   output logic       pix_ready,
   output logic [2:0] dataA,
   output logic [2:0] dataB,
   output logic [2:0] dataC,
   output logic       win_valid,
`ifdef WINGEN_OVERRUN_ERR_EN
   output logic       err,
`endif
   output logic       frame_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   logic [IMG_W-1:0] lb1_q, lb1_d, lb2_q, lb2_d;
   logic [2:0]       col_a_q, col_a_d, col_b_q, col_b_d, col_c_q, col_c_d;
   logic [2:0]       data_a_q, data_a_d, data_b_q, data_b_d, data_c_q, data_c_d;
   logic             win_valid_q, win_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             pix_ready_q, pix_ready_d;
   logic             accept, row_end;
   logic [2:0]       shift_a, shift_b, shift_c;

   // The oldest line-buffer bit is the pixel one row up in the same column.
   always_comb begin
      accept  = pix_valid & pix_ready_q;
      row_end = (col_q == COL_LAST);
      shift_a = (col_q == '0) ? {lb2_q[IMG_W-1], 2'b00} : {lb2_q[IMG_W-1], col_a_q[2:1]};
      shift_b = (col_q == '0) ? {lb1_q[IMG_W-1], 2'b00} : {lb1_q[IMG_W-1], col_b_q[2:1]};
      shift_c = (col_q == '0) ? {pix_in, 2'b00}         : {pix_in, col_c_q[2:1]};

      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      lb1_d       = lb1_q;
      lb2_d       = lb2_q;
      col_a_d     = col_a_q;
      col_b_d     = col_b_q;
      col_c_d     = col_c_q;
      data_a_d    = data_a_q;
      data_b_d    = data_b_q;
      data_c_d    = data_c_q;
      win_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               col_d   = '0;
               row_d   = '0;
            end
         end
         FILL, STREAM: begin
            if (accept) begin
               lb1_d   = {lb1_q[IMG_W-2:0], pix_in};
               lb2_d   = {lb2_q[IMG_W-2:0], lb1_q[IMG_W-1]};
               col_a_d = shift_a;
               col_b_d = shift_b;
               col_c_d = shift_c;
               col_d   = row_end ? '0 : col_q + CW'(1);
               if (row_end) begin
                  row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
               end
               if ((state_q == STREAM) && (col_q >= CW'(2))) begin
                  data_a_d    = shift_a;
                  data_b_d    = shift_b;
                  data_c_d    = shift_c;
                  win_valid_d = 1'b1;
               end
               if ((state_q == FILL) && row_end && (row_q == RW'(1))) begin
                  state_d = STREAM;
               end
               if ((state_q == STREAM) && row_end && (row_q == ROW_LAST)) begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      pix_ready_d  = (state_d == FILL) || (state_d == STREAM);
      frame_done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         lb1_q        <= '0;
         lb2_q        <= '0;
         col_a_q      <= '0;
         col_b_q      <= '0;
         col_c_q      <= '0;
         data_a_q     <= '0;
         data_b_q     <= '0;
         data_c_q     <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         pix_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         lb1_q        <= lb1_d;
         lb2_q        <= lb2_d;
         col_a_q      <= col_a_d;
         col_b_q      <= col_b_d;
         col_c_q      <= col_c_d;
         data_a_q     <= data_a_d;
         data_b_q     <= data_b_d;
         data_c_q     <= data_c_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         pix_ready_q  <= pix_ready_d;
      end
   end

`ifdef WINGEN_OVERRUN_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if ((state_q == IDLE) && start) begin
         err_d = 1'b0;
      end else if (pix_valid && ((state_q == IDLE) || (state_q == DONE))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

   // Oldest column bit only exists to mirror the window layout; it is never read back.
   logic unused_col_lsb;
   assign unused_col_lsb = ^{col_a_q[0], col_b_q[0], col_c_q[0]};

   assign pix_ready  = pix_ready_q;
   assign dataA      = data_a_q;
   assign dataB      = data_b_q;
   assign dataC      = data_c_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter IMG_W, default 8, pixels per row (legal range 3..256).
REQ-002 Parameter IMG_H, default 8, rows per frame (legal range 3..256).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  single-cycle frame start request.
REQ-006 pix_valid  input  1  pix_in holds a valid pixel.
REQ-007 pix_in  input  1  binary pixel, raster order, row-major.
REQ-008 pix_ready  output  1  block accepts a pixel this cycle.
REQ-009 dataA  output  3  window top row (row r-2), registered.
REQ-010 dataB  output  3  window middle row (row r-1), registered.
REQ-011 dataC  output  3  window bottom row (row r), registered.
REQ-012 win_valid  output  1  dataA/B/C hold a new window, one-cycle pulse.
REQ-013 frame_done  output  1  one-cycle pulse after the last frame pixel is accepted.

Function
REQ-014 Pixel transfer occurs only on a rising edge with pix_valid=1 and pix_ready=1; pix_valid with pix_ready=0 has no effect.
REQ-015 FSM states IDLE, FILL, STREAM, DONE; pix_ready=1 only in FILL and STREAM.
REQ-016 IDLE->FILL on start=1; start in any other state is ignored.
REQ-017 col counter 0..IMG_W-1 and row counter 0..IMG_H-1 increment per accepted pixel; col wraps to 0 and row increments when col=IMG_W-1.
REQ-018 FILL->STREAM when the pixel at row 1, col IMG_W-1 is accepted.
REQ-019 STREAM->DONE when the pixel at row IMG_H-1, col IMG_W-1 is accepted; DONE->IDLE unconditionally next cycle; frame_done=1 only in DONE.
REQ-020 Two line buffers of IMG_W bits hold rows r-1 and r-2; each accepted pixel shifts the new pixel into row-r tap and the displaced bits into the older buffers.
REQ-021 Three 3-bit column shift registers per row; bit[2] is the newest column (c), bit[1] is c-1, bit[0] is c-2.
REQ-022 In STREAM, a pixel accepted at row r, col c >= 2 updates dataA/B/C and pulses win_valid on the next cycle (latency 1 cycle); no window is produced for c < 2.
REQ-023 Windows per frame = (IMG_W-2)*(IMG_H-2); 36 for defaults.
REQ-024 dataA/B/C hold their last value when win_valid=0.
REQ-025 Column shift registers restart at each row, so no window spans two rows.
REQ-026 Gaps in pix_valid stall all counters and buffers with state held.

Reset
REQ-027 rst_n=0 immediately forces FSM to IDLE, counters to 0, line buffers and column registers to 0, dataA/B/C=3'b000, win_valid=0, frame_done=0, pix_ready=0.
REQ-028 Reset mid-frame discards the partial frame; a new start is required after rst_n deasserts.

Configuration
REQ-029 Macro WINGEN_OVERRUN_ERR_EN: when defined, adds output err (1 bit), set sticky when pix_valid=1 while state is IDLE or DONE, cleared only by rst_n=0 or start=1 in IDLE.
REQ-030 Without WINGEN_OVERRUN_ERR_EN, port err is absent and pixels presented while pix_ready=0 are silently ignored.

Verification
REQ-031 Defaults, start, 64 ones with pix_valid continuous -> exactly 36 win_valid pulses, each dataA=dataB=dataC=3'b111, frame_done single pulse one cycle after 64th accept, then pix_ready=0.
REQ-032 Checkerboard pixel=(r+c)%2 -> first window (r=2,c=2) dataA=3'b010, dataB=3'b101, dataC=3'b010; next (c=3) dataA=3'b101, dataB=3'b010, dataC=3'b101.
REQ-033 Same frame with pix_valid low every other cycle -> identical window sequence, 36 pulses, no duplicates.
REQ-034 rst_n low after 30 accepted pixels -> all outputs zero asynchronously; new start plus 64 pixels -> 36 windows matching REQ-031.
REQ-035 start pulsed during STREAM -> ignored; counters continue, 36 windows total.
REQ-036 WINGEN_OVERRUN_ERR_EN defined, pix_valid=1 in IDLE before start -> err=1 held until start in IDLE; macro undefined -> no err port, no window produced.
